// File: rtl/game_ctrl.sv
// Whac-A-Mole top-level sequencer: button debouncing, game state machine, second timer, best score.
// Latency: a clean button edge becomes a press pulse 2+DEBOUNCE_CYCLES+1 edges after first sample; state follows one edge later.
// No flow control: presses that mean nothing in the current state are dropped, never queued.
module game_ctrl #(
  parameter int TICK_DIV          = 100_000_000,
  parameter int DEBOUNCE_CYCLES   = 1_000_000,
  parameter int GAME_SECONDS      = 60,
  parameter int COUNTDOWN_SECONDS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_btn,
  input  logic       pause_btn,
  input  logic       scorezero,
  input  logic [8:0] score,
  output logic [4:0] state,
  output logic       logic_rst,
  output logic [6:0] time_left,
  output logic [1:0] countdown,
  output logic [7:0] best_score,
  output logic       game_over
);

  // Counter widths; the debounce counter must hold DEBOUNCE_CYCLES-1 even when that is 0.
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [4:0] {
    S_IDLE      = 5'd0,
    S_SETUP     = 5'd1,
    S_COUNTDOWN = 5'd2,
    S_PLAY      = 5'd3,
    S_PAUSE     = 5'd4,
    S_OVER      = 5'd5
  } state_t;

  state_t state_q;

  // Bit 0 is the start button, bit 1 the pause button.
  logic [1:0]         btn_raw;
  logic [1:0]         sync1;
  logic [1:0]         sync2;
  logic [1:0]         deb;
  logic [1:0]         deb_d;
  logic [1:0]         press;
  logic [1:0][DW-1:0] deb_cnt;

  logic          start_press;
  logic          pause_press;
  logic [TW-1:0] tick_cnt;
  logic          sec_tick;

  // Score bit 8 is a sign/overflow bit from gamelogic that the best-score path does not use.
  logic score_unused;

  assign btn_raw      = {pause_btn, start_btn};
  assign start_press  = press[0];
  assign pause_press  = press[1];
  assign sec_tick     = (tick_cnt == TICK_MAX);
  assign state        = state_q;
  assign score_unused = score[8];

  // Per-button synchronizer, debounce counter and rising-edge press pulse.
  // The debounced level only moves after the synchronized level has disagreed
  // with it for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= '0;
      sync2   <= '0;
      deb     <= '0;
      deb_d   <= '0;
      press   <= '0;
      deb_cnt <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      deb_d <= deb;
      press <= deb & ~deb_d;
      for (int b = 0; b < 2; b++) begin
        if (sync2[b] == deb[b]) begin
          deb_cnt[b] <= '0;
        end else if (deb_cnt[b] == DEB_MAX) begin
          deb_cnt[b] <= '0;
          deb[b]     <= sync2[b];
        end else begin
          deb_cnt[b] <= deb_cnt[b] + 1'b1;
        end
      end
    end
  end

  // Game state machine together with the second timer and all registered outputs.
  // The second timer free-runs in COUNTDOWN and PLAY, freezes in PAUSE so a resumed
  // round keeps its partial second, and is cleared everywhere else and on entry to PLAY
  // from COUNTDOWN so the first played second is a full one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      logic_rst  <= 1'b1;
      time_left  <= '0;
      countdown  <= '0;
      best_score <= '0;
      game_over  <= 1'b0;
      tick_cnt   <= '0;
    end else begin
      game_over <= 1'b0;
      case (state_q)
        S_IDLE: begin
          tick_cnt <= '0;
          if (start_press) begin
            state_q   <= S_SETUP;
            logic_rst <= 1'b0;
          end
        end

        S_SETUP: begin
          tick_cnt <= '0;
          if (start_press) begin
            state_q   <= S_COUNTDOWN;
            countdown <= 2'(COUNTDOWN_SECONDS);
          end
        end

        S_COUNTDOWN: begin
          if (sec_tick) begin
            tick_cnt <= '0;
            if (countdown == 2'd1) begin
              state_q   <= S_PLAY;
              time_left <= 7'(GAME_SECONDS);
            end else begin
              countdown <= countdown - 2'd1;
            end
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end

        S_PLAY: begin
          tick_cnt <= sec_tick ? '0 : tick_cnt + 1'b1;
          if (scorezero || (sec_tick && time_left == 7'd1)) begin
            // Game ends: flag it for one cycle and latch a new record if beaten.
            state_q   <= S_OVER;
            game_over <= 1'b1;
            if (sec_tick && time_left == 7'd1) begin
              time_left <= '0;
            end
            if (score[7:0] > best_score) begin
              best_score <= score[7:0];
            end
          end else begin
            if (pause_press) begin
              state_q <= S_PAUSE;
            end
            if (sec_tick) begin
              time_left <= time_left - 7'd1;
            end
          end
        end

        S_PAUSE: begin
          // Timer held; scorezero cannot end a paused round.
          if (pause_press) begin
            state_q <= S_PLAY;
          end
        end

        S_OVER: begin
          tick_cnt <= '0;
          if (start_press) begin
            state_q   <= S_IDLE;
            logic_rst <= 1'b1;
            time_left <= '0;
            countdown <= '0;
          end
        end

        default: begin
          // Unreachable encodings fall back to a clean IDLE.
          state_q   <= S_IDLE;
          logic_rst <= 1'b1;
          time_left <= '0;
          countdown <= '0;
          tick_cnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl with small timing parameters.
module tb_game_ctrl;

  localparam int TD = 10;
  localparam int DB = 4;
  localparam int GS = 5;
  localparam int CS = 3;

  logic       clk;
  logic       rst_n;
  logic       start_btn;
  logic       pause_btn;
  logic       scorezero;
  logic [8:0] score;
  logic [4:0] state;
  logic       logic_rst;
  logic [6:0] time_left;
  logic [1:0] countdown;
  logic [7:0] best_score;
  logic       game_over;

  int errors = 0;
  int checks = 0;

  game_ctrl #(
    .TICK_DIV(TD),
    .DEBOUNCE_CYCLES(DB),
    .GAME_SECONDS(GS),
    .COUNTDOWN_SECONDS(CS)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start_btn(start_btn),
    .pause_btn(pause_btn),
    .scorezero(scorezero),
    .score(score),
    .state(state),
    .logic_rst(logic_rst),
    .time_left(time_left),
    .countdown(countdown),
    .best_score(best_score),
    .game_over(game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs at a given cycle offset from COUNTDOWN entry (offset 0 = first negedge in COUNTDOWN).
  typedef struct {
    int         cyc;
    logic [4:0] st;
    logic [6:0] tl;
    logic [1:0] cd;
    logic       go;
    logic [7:0] best;
  } vec_t;

  localparam int NV = 15;
  vec_t vec [NV];

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_state(input logic [4:0] exp, input int budget, input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (state == exp) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s: state=%0d after %0d cycles, expected %0d", nm, state, budget, exp);
    end
  endtask

  // Hold a button until the expected state appears, then release it.
  task automatic press_to(input int which, input logic [4:0] exp, input string nm);
    if (which == 0) start_btn = 1'b1;
    else            pause_btn = 1'b1;
    wait_state(exp, 20, nm);
    start_btn = 1'b0;
    pause_btn = 1'b0;
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_state"}, state, 0);
    chk({nm, "_lrst"}, logic_rst, 1);
    chk({nm, "_tl"}, time_left, 0);
    chk({nm, "_cd"}, countdown, 0);
    chk({nm, "_best"}, best_score, 0);
    chk({nm, "_go"}, game_over, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int j;
    bit bad;

    vec[0]  = '{0,  5'd2, 7'd0, 2'd3, 1'b0, 8'd0};
    vec[1]  = '{9,  5'd2, 7'd0, 2'd3, 1'b0, 8'd0};
    vec[2]  = '{10, 5'd2, 7'd0, 2'd2, 1'b0, 8'd0};
    vec[3]  = '{19, 5'd2, 7'd0, 2'd2, 1'b0, 8'd0};
    vec[4]  = '{20, 5'd2, 7'd0, 2'd1, 1'b0, 8'd0};
    vec[5]  = '{29, 5'd2, 7'd0, 2'd1, 1'b0, 8'd0};
    vec[6]  = '{30, 5'd3, 7'd5, 2'd1, 1'b0, 8'd0};
    vec[7]  = '{39, 5'd3, 7'd5, 2'd1, 1'b0, 8'd0};
    vec[8]  = '{40, 5'd3, 7'd4, 2'd1, 1'b0, 8'd0};
    vec[9]  = '{50, 5'd3, 7'd3, 2'd1, 1'b0, 8'd0};
    vec[10] = '{60, 5'd3, 7'd2, 2'd1, 1'b0, 8'd0};
    vec[11] = '{70, 5'd3, 7'd1, 2'd1, 1'b0, 8'd0};
    vec[12] = '{79, 5'd3, 7'd1, 2'd1, 1'b0, 8'd0};
    vec[13] = '{80, 5'd5, 7'd0, 2'd1, 1'b1, 8'd72};
    vec[14] = '{81, 5'd5, 7'd0, 2'd1, 1'b0, 8'd72};

    rst_n     = 1'b0;
    start_btn = 1'b0;
    pause_btn = 1'b0;
    scorezero = 1'b0;
    score     = 9'd72;

    // 1: reset values, quiet buttons, short glitch rejected.
    idle(3);
    chk_reset_vals("in_reset");
    rst_n = 1'b1;
    idle(50);
    chk_reset_vals("idle50");
    start_btn = 1'b1;
    idle(3);
    start_btn = 1'b0;
    idle(20);
    chk("glitch_state", state, 0);

    // 2+3: full game to timeout driven from the vector table.
    press_to(0, 5'd1, "to_setup");
    chk("setup_lrst", logic_rst, 0);
    idle(12);
    press_to(0, 5'd2, "to_countdown");
    for (int k = 0; k <= 81; k++) begin
      if (k != 0) @(negedge clk);
      for (int v = 0; v < NV; v++) begin
        if (vec[v].cyc == k) begin
          chk($sformatf("v%0d_state", k), state, vec[v].st);
          chk($sformatf("v%0d_tl", k), time_left, vec[v].tl);
          chk($sformatf("v%0d_cd", k), countdown, vec[v].cd);
          chk($sformatf("v%0d_go", k), game_over, vec[v].go);
          chk($sformatf("v%0d_best", k), best_score, vec[v].best);
          chk($sformatf("v%0d_lrst", k), logic_rst, 0);
        end
      end
    end
    press_to(0, 5'd0, "over_to_idle");
    chk("idle_lrst", logic_rst, 1);
    chk("idle_tl", time_left, 0);
    chk("idle_cd", countdown, 0);

    // 4: pause mid-second, hold, resume keeps the partial second.
    idle(12);
    press_to(0, 5'd1, "g2_setup");
    idle(12);
    press_to(0, 5'd2, "g2_countdown");
    wait_state(5'd3, 40, "g2_play");
    chk("g2_tl_start", time_left, 5);
    idle(6);
    pause_btn = 1'b1;
    j = 0;
    while (time_left != 7'd4 && j < 15) begin
      @(negedge clk);
      j++;
    end
    chk("g2_first_dec", time_left, 4);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (state != 5'd3) break;
      n++;
    end
    pause_btn = 1'b0;
    chk("g2_paused", state, 4);
    chk("g2_tl_at_pause", time_left, 4);
    scorezero = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (state != 5'd4 || time_left != 7'd4) bad = 1'b1;
    end
    scorezero = 1'b0;
    chk("g2_pause_hold", bad, 0);
    press_to(1, 5'd3, "g2_resume");
    j = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      j++;
      if (time_left != 7'd4) break;
    end
    chk("g2_resume_gap", j, 9 - n);
    chk("g2_tl_after", time_left, 3);
    wait_state(5'd5, 60, "g2_over");
    chk("g2_go", game_over, 1);
    chk("g2_best", best_score, 72);
    press_to(0, 5'd0, "g2_idle");

    // 5: scorezero beats a simultaneous pause press; lower score keeps the record.
    idle(12);
    press_to(0, 5'd1, "g3_setup");
    idle(12);
    press_to(0, 5'd2, "g3_countdown");
    wait_state(5'd3, 40, "g3_play");
    score = 9'd40;
    idle(3);
    pause_btn = 1'b1;
    idle(7);
    scorezero = 1'b1;
    @(negedge clk);
    scorezero = 1'b0;
    pause_btn = 1'b0;
    chk("g3_state", state, 5);
    chk("g3_go", game_over, 1);
    chk("g3_best", best_score, 72);
    idle(12);
    press_to(0, 5'd0, "g3_idle");
    chk("g3_lrst", logic_rst, 1);

    // 6: asynchronous reset in the middle of PLAY.
    idle(12);
    press_to(0, 5'd1, "g4_setup");
    idle(12);
    press_to(0, 5'd2, "g4_countdown");
    wait_state(5'd3, 40, "g4_play");
    idle(5);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
# game_ctrl

Top-level sequencer for the Whac-A-Mole game. It debounces the start and pause buttons and runs the game state machine. It drives the 5-bit `state` bus and the active-high reset consumed by `gamelogic`, and times the countdown and play round in whole seconds. It also ends the game on timeout or on `scorezero`, and keeps a best-score register for the display.

## Interface
- `TICK_DIV`, 100_000_000: clk cycles per second tick, ≥2.
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive stable synchronized cycles needed to accept a button level, ≥1.
- `GAME_SECONDS`, 60: play-round length in seconds, 1..127.
- `COUNTDOWN_SECONDS`, 3: pre-play countdown in seconds, 1..3.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start_btn`  in  1  raw start button, active-high, asynchronous.
- `pause_btn`  in  1  raw pause button, active-high, asynchronous.
- `scorezero`  in  1  from `gamelogic`; score has reached 0.
- `score`  in  9  from `gamelogic`; only bits [7:0] are used.
- `state`  out  5  game state to `gamelogic` and the display.
- `logic_rst`  out  1  active-high reset for `gamelogic`.
- `time_left`  out  7  seconds remaining in the round.
- `countdown`  out  2  countdown seconds remaining.
- `best_score`  out  8  highest final score since `rst_n`.
- `game_over`  out  1  one-cycle pulse on entry to OVER.

## Operation
- Button path, per button:
  - 2-flop synchronizer, then debounce counter.
  - The debounced level changes only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles. Any bounce restarts the count.
  - A debounced 0→1 transition produces a one-cycle press pulse. Release produces nothing.
- State encoding: IDLE=0, SETUP=1, COUNTDOWN=2, PLAY=3, PAUSE=4, OVER=5. Values 6..31 are never driven; if reached, the next state is IDLE.
- Second timer: counts 0..TICK_DIV-1 and pulses `sec_tick` when the count equals TICK_DIV-1.
  - Runs only in COUNTDOWN and PLAY.
  - Held (not cleared) in PAUSE.
  - Cleared on entry to COUNTDOWN and to PLAY, and in every other state.
- Transitions:
  - IDLE: start press → SETUP.
  - SETUP (`gamelogic` captures the target switches): start press → COUNTDOWN, load `countdown`=COUNTDOWN_SECONDS.
  - COUNTDOWN: on `sec_tick`, if `countdown`==1 → PLAY and load `time_left`=GAME_SECONDS; otherwise decrement `countdown`.
  - PLAY, in priority order:
    - `scorezero` → OVER.
    - `sec_tick` with `time_left`==1 → OVER, `time_left`=0.
    - pause press → PAUSE. A `sec_tick` in the same cycle still decrements `time_left`.
    - `sec_tick` alone → decrement `time_left`.
  - PAUSE: pause press → PLAY. `scorezero` is ignored.
  - OVER: start press → IDLE.
- Presses that have no meaning in the current state are discarded, not queued. Examples: start in PLAY or PAUSE, pause outside PLAY or PAUSE.
- `logic_rst` is high exactly while `state`==IDLE (registered together with `state`).
- Best score: on the OVER entry cycle, if `score[7:0]` > `best_score`, load it. Equal values do not reload. Cleared only by `rst_n`.
- `time_left` and `countdown` hold their values in all states except where loaded or decremented above. Both clear to 0 on entry to IDLE.

## Timing
- Reset values, asynchronous, while `rst_n`=0:
  - `state`=0, `logic_rst`=1, `time_left`=0, `countdown`=0, `best_score`=0, `game_over`=0.
  - Synchronizers, debounce counters and second timer all 0.
- Reset asserted mid-game returns immediately to IDLE with all of the above. `best_score` is lost.
- Press latency: for a clean raw edge, the press pulse is high 2+DEBOUNCE_CYCLES+1 cycles after the first clk edge that samples it high. `state` changes on the next edge.
- COUNTDOWN lasts exactly COUNTDOWN_SECONDS×TICK_DIV cycles. PLAY without pause or `scorezero` lasts GAME_SECONDS×TICK_DIV cycles.
- `scorezero` is sampled synchronously (it comes from the same clock domain) and ends PLAY on the next edge.
- `game_over` is high for the first cycle with `state`==5, registered alongside the `best_score` update.

## Test plan
Bench parameters: TICK_DIV=10, DEBOUNCE_CYCLES=4, GAME_SECONDS=5, COUNTDOWN_SECONDS=3.

1. Reset, then hold both buttons low for 50 cycles → `state`=0, `logic_rst`=1, all other outputs 0. Pulse `start_btn` high for only 3 cycles → no state change.
2. Start press → `state`=1 and `logic_rst`=0. Second press → `state`=2, `countdown` reads 3,2,1 at 10-cycle spacing. After 30 cycles in COUNTDOWN → `state`=3, `time_left`=5.
3. In PLAY, leave `scorezero`=0 → `time_left` steps 5→1 every 10 cycles. After 50 cycles → `state`=5, `time_left`=0, `game_over` high 1 cycle. With `score`=9'd72 → `best_score`=72.
4. Pause press 4 cycles into a second → `state`=4, `time_left` frozen for 100 cycles. Second pause press → `state`=3, and the next decrement occurs 6 cycles later.
5. `scorezero`=1 and a pause press in the same PLAY cycle → `state`=5, not 4. Next game ends with `score`=9'd40 → `best_score` stays 72. Start press in OVER → `state`=0, `logic_rst`=1.
6. Assert `rst_n`=0 mid-PLAY → all outputs take reset values asynchronously, including `best_score`=0.
